// File: rtl/sha256_single_block_core_if.sv
// SHA-256 core request/response bundle between the hash_drbg initiator and the core.
interface sha256_single_block_core_if;
  logic         sha_reset_n;
  logic         sha_init;
  logic [511:0] sha_block;
  logic         sha_ready;
  logic [255:0] sha_digest;
  logic         sha_digest_valid;

  modport master (
    output sha_reset_n, sha_init, sha_block,
    input  sha_ready, sha_digest, sha_digest_valid
  );

  modport slave (
    input  sha_reset_n, sha_init, sha_block,
    output sha_ready, sha_digest, sha_digest_valid
  );
endinterface

// File: rtl/sha256_single_block_core.sv
// Iterative single-block SHA-256 core with fixed FIPS 180-4 IV, one round per clock.
// Define SHA256_UNROLL2_EN to run two chained rounds per clock (33-cycle latency).
module sha256_single_block_core (
  input  logic                         clk,
  input  logic                         reset,
  sha256_single_block_core_if.slave    sha
);

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 256;
  localparam int unsigned NWORDS   = 16;
  localparam int unsigned NROUNDS  = 64;
  localparam int unsigned CNT_W    = 6;

`ifdef SHA256_UNROLL2_EN
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(62);
`else
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(63);
`endif

  localparam logic [DIGEST_W-1:0] IV_VEC = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [WORD_W-1:0] K_TAB [NROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // One compression round on the packed working set {a,b,c,d,e,f,g,h}.
  function automatic logic [DIGEST_W-1:0] sha_round(input logic [DIGEST_W-1:0] s,
                                                    input logic [WORD_W-1:0]   k,
                                                    input logic [WORD_W-1:0]   w);
    logic [WORD_W-1:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k + w;
    t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DIGEST_W-1:0] hv_q;
  logic [WORD_W-1:0]   w_q [NWORDS];
  logic [DIGEST_W-1:0] digest_q;
  logic                ready_q;
  logic                valid_q;

  logic                load_c, round_c, final_c;
  logic [DIGEST_W-1:0] hv_rnd_c;
  logic [DIGEST_W-1:0] digest_c;
  logic [WORD_W-1:0]   w_new0_c;
`ifdef SHA256_UNROLL2_EN
  logic [WORD_W-1:0]   w_new1_c;
`endif

  assign sha.sha_ready        = ready_q;
  assign sha.sha_digest       = digest_q;
  assign sha.sha_digest_valid = valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; soft clear overrides every state.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    round_c = 1'b0;
    final_c = 1'b0;
    if (!sha.sha_reset_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sha.sha_init) begin
            load_c  = 1'b1;
            state_d = ROUND;
          end
        end
        ROUND: begin
          round_c = 1'b1;
          if (cnt_q == LAST_CNT) state_d = FINAL;
        end
        FINAL: begin
          final_c = 1'b1;
          state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Round datapath and message-schedule extension from the sliding window.
  always_comb begin
    hv_rnd_c = sha_round(hv_q, K_TAB[cnt_q], w_q[0]);
    w_new0_c = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
`ifdef SHA256_UNROLL2_EN
    hv_rnd_c = sha_round(hv_rnd_c, K_TAB[cnt_q | CNT_W'(1)], w_q[1]);
    w_new1_c = small_sigma1(w_q[15]) + w_q[10] + small_sigma0(w_q[2]) + w_q[1];
`endif
  end

  always_comb begin
    digest_c = '0;
    for (int i = 0; i < 8; i++) begin
      digest_c[DIGEST_W-1-WORD_W*i -: WORD_W] =
        IV_VEC[DIGEST_W-1-WORD_W*i -: WORD_W] + hv_q[DIGEST_W-1-WORD_W*i -: WORD_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      hv_q     <= '0;
      digest_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      for (int i = 0; i < NWORDS; i++) w_q[i] <= '0;
    end else begin
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
      if (load_c) begin
        cnt_q <= '0;
        hv_q  <= IV_VEC;
        for (int i = 0; i < NWORDS; i++) w_q[i] <= sha.sha_block[BLOCK_W-1-WORD_W*i -: WORD_W];
      end
      if (round_c) begin
        cnt_q <= cnt_q + CNT_STEP;
        hv_q  <= hv_rnd_c;
`ifdef SHA256_UNROLL2_EN
        for (int i = 0; i < NWORDS-2; i++) w_q[i] <= w_q[i+2];
        w_q[NWORDS-2] <= w_new0_c;
        w_q[NWORDS-1] <= w_new1_c;
`else
        for (int i = 0; i < NWORDS-1; i++) w_q[i] <= w_q[i+1];
        w_q[NWORDS-1] <= w_new0_c;
`endif
      end
      if (final_c) digest_q <= digest_c;
    end
  end

endmodule

// File: tb/tb_sha256_single_block_core.sv
// Directed bench for sha256_single_block_core: known-answer digests, latency, handshake and clears.
module tb_sha256_single_block_core;

`ifdef SHA256_UNROLL2_EN
  localparam int LAT       = 33;
  localparam int ABORT_CYC = 15;
`else
  localparam int LAT       = 65;
  localparam int ABORT_CYC = 30;
`endif
  localparam int WAIT_MAX = 200;

  localparam logic [255:0] DIG_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [511:0] blk_abc, blk_empty;

  always #5 clk = ~clk;

  sha256_single_block_core_if sif();

  sha256_single_block_core dut (
    .clk   (clk),
    .reset (reset),
    .sha   (sif.slave)
  );

  // Drive a start on the coming edge (E0) and return #1 after it.
  task automatic start_block(input logic [511:0] b);
    @(negedge clk);
    sif.sha_block   = b;
    sif.sha_init    = 1'b1;
    sif.sha_reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (sif.sha_digest_valid !== 1'b1 && n < WAIT_MAX) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic soft_clear_idle();
    @(negedge clk);
    sif.sha_init    = 1'b0;
    sif.sha_reset_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    sif.sha_init    = 1'b0;
    sif.sha_reset_n = 1'b0;
    sif.sha_block   = '0;
    #2;
    total++; if (sif.sha_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", sif.sha_ready); end
    total++; if (sif.sha_digest_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", sif.sha_digest_valid); end
    total++; if (sif.sha_digest !== 256'd0) begin bad++; $display("FAIL reset_digest got=%h want=0", sif.sha_digest); end
    #20;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++; if (sif.sha_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", sif.sha_ready); end
  endtask

  task automatic test_abc();
    int n;
    start_block(blk_abc);
    total++; if (sif.sha_ready !== 1'b0) begin bad++; $display("FAIL abc_busy_ready got=%b want=0", sif.sha_ready); end
    wait_valid(n);
    total++; if (n != LAT) begin bad++; $display("FAIL abc_latency got=%0d want=%0d", n, LAT); end
    total++; if (sif.sha_digest !== DIG_ABC) begin bad++; $display("FAIL abc_digest got=%h want=%h", sif.sha_digest, DIG_ABC); end
    total++; if (sif.sha_ready !== 1'b0) begin bad++; $display("FAIL abc_done_ready got=%b want=0", sif.sha_ready); end
  endtask

  // sha_init is still high from test_abc.
  task automatic test_held_init();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      total++; if (sif.sha_digest_valid !== 1'b1) begin bad++; $display("FAIL held_valid cyc=%0d got=%b want=1", i, sif.sha_digest_valid); end
      total++; if (sif.sha_ready !== 1'b0) begin bad++; $display("FAIL held_ready cyc=%0d got=%b want=0", i, sif.sha_ready); end
      total++; if (sif.sha_digest !== DIG_ABC) begin bad++; $display("FAIL held_digest cyc=%0d got=%h want=%h", i, sif.sha_digest, DIG_ABC); end
    end
    soft_clear_idle();
    total++; if (sif.sha_digest_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", sif.sha_digest_valid); end
    total++; if (sif.sha_ready !== 1'b1) begin bad++; $display("FAIL clr_ready got=%b want=1", sif.sha_ready); end
    total++; if (sif.sha_digest !== DIG_ABC) begin bad++; $display("FAIL clr_digest_kept got=%h want=%h", sif.sha_digest, DIG_ABC); end
  endtask

  task automatic test_soft_clear_mid();
    int   n;
    logic seen;
    seen = 1'b0;
    start_block(blk_abc);
    for (int i = 0; i < ABORT_CYC; i++) begin
      @(posedge clk);
      #1;
      if (sif.sha_digest_valid !== 1'b0) seen = 1'b1;
    end
    @(negedge clk);
    sif.sha_reset_n = 1'b0;
    @(posedge clk);
    #1;
    total++; if (sif.sha_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", sif.sha_ready); end
    total++; if (seen !== 1'b0 || sif.sha_digest_valid !== 1'b0) begin bad++; $display("FAIL abort_valid seen=%b now=%b want=0", seen, sif.sha_digest_valid); end
    start_block(blk_empty);
    wait_valid(n);
    total++; if (n != LAT) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", n, LAT); end
    total++; if (sif.sha_digest !== DIG_EMPTY) begin bad++; $display("FAIL empty_digest got=%h want=%h", sif.sha_digest, DIG_EMPTY); end
    soft_clear_idle();
  endtask

  task automatic test_async_reset_mid();
    int n;
    start_block(blk_abc);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++; if (sif.sha_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%b want=1", sif.sha_ready); end
    total++; if (sif.sha_digest_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b want=0", sif.sha_digest_valid); end
    total++; if (sif.sha_digest !== 256'd0) begin bad++; $display("FAIL areset_digest got=%h want=0", sif.sha_digest); end
    @(negedge clk);
    reset           = 1'b0;
    sif.sha_init    = 1'b0;
    sif.sha_reset_n = 1'b0;
    @(posedge clk);
    #1;
    start_block(blk_abc);
    wait_valid(n);
    total++; if (n != LAT) begin bad++; $display("FAIL post_reset_latency got=%0d want=%0d", n, LAT); end
    total++; if (sif.sha_digest !== DIG_ABC) begin bad++; $display("FAIL post_reset_digest got=%h want=%h", sif.sha_digest, DIG_ABC); end
    soft_clear_idle();
  endtask

  // Initiator loop in the style of hash_drbg: start only on ready && !valid.
  task automatic test_back_to_back();
    int n;
    logic [255:0] want;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      while (!(sif.sha_ready === 1'b1 && sif.sha_digest_valid === 1'b0) && n < WAIT_MAX) begin
        @(posedge clk);
        #1;
        n++;
      end
      total++; if (sif.sha_ready !== 1'b1 || sif.sha_digest_valid !== 1'b0) begin bad++; $display("FAIL b2b_gate txn=%0d ready=%b valid=%b want ready=1 valid=0", t, sif.sha_ready, sif.sha_digest_valid); end
      want = (t % 2 == 0) ? DIG_ABC : DIG_EMPTY;
      start_block((t % 2 == 0) ? blk_abc : blk_empty);
      wait_valid(n);
      total++; if (n != LAT) begin bad++; $display("FAIL b2b_latency txn=%0d got=%0d want=%0d", t, n, LAT); end
      total++; if (sif.sha_digest !== want) begin bad++; $display("FAIL b2b_digest txn=%0d got=%h want=%h", t, sif.sha_digest, want); end
      soft_clear_idle();
    end
  endtask

  initial begin
    blk_abc          = '0;
    blk_abc[511:480] = 32'h61626380;
    blk_abc[63:0]    = 64'h18;
    blk_empty        = '0;
    blk_empty[511]   = 1'b1;

    test_reset();
    test_abc();
    test_held_init();
    test_soft_clear_mid();
    test_async_reset_mid();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
